data_mem_arbiter: RTL and testbench

Downstream neighbour of the compute unit's per-thread LSU ports. It arbitrates the NUM_THREADS read and write request channels onto a single data-memory port, one transaction outstanding at a time. It returns each response to the issuing thread using the same val/rdy channel semantics the LSU already uses. Default arbitration is round-robin across threads.

---
 rtl/minigpu_mem_pkg.sv | 14 +
 rtl/data_mem_arbiter_rr_arbiter.sv | 39 +++
 rtl/data_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minigpu_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and memory op codes.
package minigpu_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_e;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Combinational one-hot grant from a request vector. Round-robin from ptr by default;
// lowest-index fixed priority (no ptr port) when DATA_MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0] ptr,
`endif
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] idx;

  // NOTE: every output gets a default before the loop so no path leaves a value
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
      idx = IW'(k);
`else
      idx = IW'((int'(ptr) + k) % N);
`endif
      if (req[idx] && !gnt_any) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates per-thread LSU load/store channels onto one data-memory port, one transaction
// outstanding. Optional macro DATA_MEM_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
module data_mem_arbiter
  import minigpu_mem_pkg::*;
#(
  parameter int NUM_THREADS     = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       read_req_addr_val  [NUM_THREADS],
  input  logic [DATA_ADDR_WIDTH-1:0] read_req_addr      [NUM_THREADS],
  output logic                       read_req_rdy       [NUM_THREADS],
  output logic                       read_resp_data_val [NUM_THREADS],
  output logic [DATA_WIDTH-1:0]      read_resp_data     [NUM_THREADS],
  input  logic                       read_resp_rdy      [NUM_THREADS],
  input  logic                       write_req_val      [NUM_THREADS],
  input  logic [DATA_ADDR_WIDTH-1:0] write_req_addr     [NUM_THREADS],
  input  logic [DATA_WIDTH-1:0]      write_req_data     [NUM_THREADS],
  output logic                       write_req_rdy      [NUM_THREADS],
  output logic                       write_resp_val     [NUM_THREADS],
  output logic                       mem_req_val,
  input  logic                       mem_req_rdy,
  output logic                       mem_req_wen,
  output logic [DATA_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0]      mem_req_data,
  input  logic                       mem_resp_val,
  input  logic [DATA_WIDTH-1:0]      mem_resp_data,
  output logic                       arb_busy
);

  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  arb_state_e                 state_q, state_d;
  logic [TID_W-1:0]           tid_q, tid_d;
  logic                       wen_q, wen_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [DATA_WIDTH-1:0]      rdata_q [NUM_THREADS];
  logic [DATA_WIDTH-1:0]      rdata_d [NUM_THREADS];

  logic [NUM_THREADS-1:0]     req_vec;
  logic [NUM_THREADS-1:0]     gnt;
  logic [TID_W-1:0]           gnt_idx;
  logic                       gnt_any;
  logic                       resp_done;

`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
  logic [TID_W-1:0]           rr_ptr_q, rr_ptr_d;
`endif

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      req_vec[t] = read_req_addr_val[t] | write_req_val[t];
    end
  end

  rr_arbiter #(
    .N  (NUM_THREADS),
    .IW (TID_W)
  ) u_rr_arbiter (
    .req     (req_vec),
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
    .ptr     (rr_ptr_q),
`endif
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    tid_d       = tid_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    resp_done   = 1'b0;
    mem_req_val = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      read_req_rdy[t]       = 1'b0;
      write_req_rdy[t]      = 1'b0;
      read_resp_data_val[t] = 1'b0;
      write_resp_val[t]     = 1'b0;
    end

    // Handshake outputs stay quiet while reset is asserted, whatever the current state.
    if (!reset) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (gnt_any) begin
            // Read beats write inside the granted thread.
            for (int t = 0; t < NUM_THREADS; t++) begin
              read_req_rdy[t]  = gnt[t] & read_req_addr_val[t];
              write_req_rdy[t] = gnt[t] & write_req_val[t] & ~read_req_addr_val[t];
            end
            tid_d   = gnt_idx;
            state_d = ARB_REQ;
            if (read_req_addr_val[gnt_idx]) begin
              wen_d  = MEM_OP_READ;
              addr_d = read_req_addr[gnt_idx];
            end else begin
              wen_d  = MEM_OP_WRITE;
              addr_d = write_req_addr[gnt_idx];
              data_d = write_req_data[gnt_idx];
            end
          end
        end
        ARB_REQ: begin
          mem_req_val = 1'b1;
          if (mem_req_rdy) state_d = ARB_WAIT;
        end
        ARB_WAIT: begin
          if (mem_resp_val) begin
            if (wen_q == MEM_OP_READ) rdata_d[tid_q] = mem_resp_data;
            state_d = ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (wen_q == MEM_OP_READ) begin
            read_resp_data_val[tid_q] = 1'b1;
            resp_done                 = read_resp_rdy[tid_q];
          end else begin
            write_resp_val[tid_q] = 1'b1;
            resp_done             = 1'b1;
          end
          if (resp_done) state_d = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
  // The thread just served drops to lowest priority for the next grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (resp_done) begin
      rr_ptr_d = (tid_q == TID_W'(NUM_THREADS - 1)) ? '0 : tid_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      tid_q   <= '0;
      wen_q   <= MEM_OP_READ;
      addr_q  <= '0;
      data_q  <= '0;
      // NOTE: this small register array is reset on purpose because the thread-side
      // read data must read 0 after reset; a true RAM array would be left unreset.
      for (int t = 0; t < NUM_THREADS; t++) rdata_q[t] <= '0;
    end else begin
      state_q <= state_d;
      tid_q   <= tid_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_req_wen    = wen_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_data   = data_q;
  assign read_resp_data = rdata_q;
  assign arb_busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: random thread traffic and a random-latency memory,
// checked against an arbitration/memory reference model, then a directed reset-in-WAIT case.
module tb_data_mem_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          read_req_addr_val  [N];
  logic [AW-1:0] read_req_addr      [N];
  logic          read_req_rdy       [N];
  logic          read_resp_data_val [N];
  logic [DW-1:0] read_resp_data     [N];
  logic          read_resp_rdy      [N];
  logic          write_req_val      [N];
  logic [AW-1:0] write_req_addr     [N];
  logic [DW-1:0] write_req_data     [N];
  logic          write_req_rdy      [N];
  logic          write_resp_val     [N];
  logic          mem_req_val, mem_req_rdy, mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic          mem_resp_val;
  logic [DW-1:0] mem_resp_data;
  logic          arb_busy;

  always #5 clk = ~clk;

  data_mem_arbiter #(.NUM_THREADS(N), .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .read_req_addr_val(read_req_addr_val), .read_req_addr(read_req_addr),
    .read_req_rdy(read_req_rdy), .read_resp_data_val(read_resp_data_val),
    .read_resp_data(read_resp_data), .read_resp_rdy(read_resp_rdy),
    .write_req_val(write_req_val), .write_req_addr(write_req_addr),
    .write_req_data(write_req_data), .write_req_rdy(write_req_rdy),
    .write_resp_val(write_resp_val),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
    .arb_busy(arb_busy)
  );

  typedef struct {
    int            tid;
    bit            wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          memq[$];
  txn_t          respq[$];
  logic [DW-1:0] ref_mem  [256];
  logic [DW-1:0] phys_mem [256];
  logic [DW-1:0] exp_last [N];
  bit            model_busy;
  int            model_ptr;
  bit            fired_rd [N];
  bit            fired_wr [N];
  bit            mem_acc;
  bit            acc_wen;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  bit            outstanding;
  bit            out_wen;
  logic [AW-1:0] out_addr;
  int            lat;
  bit            random_en;
  bit            mem_hold;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit [N-1:0] m_cand, m_act_r, m_act_w, m_exp_r, m_exp_w;
  int         m_win, m_idx;
  txn_t       m_t;

  always @(negedge clk) begin
    if (reset) begin
      memq.delete();
      respq.delete();
      model_busy = 1'b0;
      model_ptr  = 0;
      mem_acc    = 1'b0;
      for (int t = 0; t < N; t++) begin
        exp_last[t] = '0;
        fired_rd[t] = 1'b0;
        fired_wr[t] = 1'b0;
      end
    end else begin
      m_exp_r = '0;
      m_exp_w = '0;
      m_win   = -1;
      for (int t = 0; t < N; t++) begin
        m_cand[t]  = read_req_addr_val[t] | write_req_val[t];
        m_act_r[t] = read_req_rdy[t];
        m_act_w[t] = write_req_rdy[t];
      end
      if (!model_busy && m_cand != '0) begin
        for (int k = 0; k < N; k++) begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
          m_idx = k;
`else
          m_idx = (model_ptr + k) % N;
`endif
          if (m_cand[m_idx] && m_win < 0) m_win = m_idx;
        end
        if (read_req_addr_val[m_win]) m_exp_r[m_win] = 1'b1;
        else                          m_exp_w[m_win] = 1'b1;
      end
      if (m_cand != '0 || m_act_r != '0 || m_act_w != '0) begin
        check("grant_rd", 64'(m_act_r), 64'(m_exp_r));
        check("grant_wr", 64'(m_act_w), 64'(m_exp_w));
      end
      for (int t = 0; t < N; t++) begin
        fired_rd[t] = m_act_r[t] & read_req_addr_val[t];
        fired_wr[t] = m_act_w[t] & write_req_val[t];
      end
      if (m_win >= 0) begin
        m_t.tid = m_win;
        m_t.wen = !read_req_addr_val[m_win];
        if (m_t.wen) begin
          m_t.addr = write_req_addr[m_win];
          m_t.data = write_req_data[m_win];
          ref_mem[m_t.addr] = m_t.data;
        end else begin
          m_t.addr = read_req_addr[m_win];
          m_t.data = ref_mem[m_t.addr];
        end
        memq.push_back(m_t);
        respq.push_back(m_t);
        model_busy = 1'b1;
      end

      if (mem_req_val) begin
        if (memq.size() == 0) begin
          check("mem_req_unexpected", 64'(mem_req_val), 64'd0);
        end else begin
          check("mem_req_wen", 64'(mem_req_wen), 64'(memq[0].wen));
          check("mem_req_addr", 64'(mem_req_addr), 64'(memq[0].addr));
          if (memq[0].wen) check("mem_req_data", 64'(mem_req_data), 64'(memq[0].data));
          if (mem_req_rdy) begin
            mem_acc  = 1'b1;
            acc_wen  = mem_req_wen;
            acc_addr = mem_req_addr;
            acc_data = mem_req_data;
            void'(memq.pop_front());
          end
        end
      end

      for (int t = 0; t < N; t++) begin
        if (read_resp_data_val[t] || write_resp_val[t]) begin
          if (respq.size() == 0) begin
            check($sformatf("resp_unexpected_t%0d", t), 64'd1, 64'd0);
          end else begin
            m_t = respq[0];
            check("resp_tid", 64'(t), 64'(m_t.tid));
            check("resp_kind", 64'(write_resp_val[t]), 64'(m_t.wen));
            if (!m_t.wen) begin
              check("resp_data", 64'(read_resp_data[t]), 64'(m_t.data));
              exp_last[t] = m_t.data;
            end
            if (m_t.wen || read_resp_rdy[t]) begin
              void'(respq.pop_front());
              model_busy = 1'b0;
              model_ptr  = (t + 1) % N;
            end
          end
        end else begin
          check("rdata_hold", 64'(read_resp_data[t]), 64'(exp_last[t]));
        end
      end
    end
  end

  // ---------------- drivers: threads and memory ----------------
  task automatic drive_cycle();
    for (int t = 0; t < N; t++) begin
      if (fired_rd[t]) begin read_req_addr_val[t] = 1'b0; fired_rd[t] = 1'b0; end
      if (fired_wr[t]) begin write_req_val[t] = 1'b0; fired_wr[t] = 1'b0; end
      if (random_en) begin
        if (!read_req_addr_val[t]) begin
          if ($urandom_range(0, 9) < 3) begin
            read_req_addr_val[t] = 1'b1;
            read_req_addr[t]     = AW'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 39) == 0) begin
          read_req_addr_val[t] = 1'b0;
        end
        if (!write_req_val[t]) begin
          if ($urandom_range(0, 9) < 2) begin
            write_req_val[t]  = 1'b1;
            write_req_addr[t] = AW'($urandom_range(0, 15));
            write_req_data[t] = DW'($urandom);
          end
        end else if ($urandom_range(0, 39) == 0) begin
          write_req_val[t] = 1'b0;
        end
        read_resp_rdy[t] = ($urandom_range(0, 2) != 0);
      end else begin
        read_resp_rdy[t] = 1'b1;
      end
    end

    if (mem_acc) begin
      mem_acc     = 1'b0;
      outstanding = 1'b1;
      lat         = $urandom_range(0, 3);
      out_wen     = acc_wen;
      out_addr    = acc_addr;
      if (acc_wen) phys_mem[acc_addr] = acc_data;
    end
    mem_resp_val  = 1'b0;
    mem_resp_data = DW'($urandom);
    if (outstanding) begin
      if (!mem_hold) begin
        if (lat == 0) begin
          mem_resp_val = 1'b1;
          if (!out_wen) mem_resp_data = phys_mem[out_addr];
          outstanding = 1'b0;
        end else begin
          lat--;
        end
      end
    end else if ($urandom_range(0, 9) == 0) begin
      mem_resp_val = 1'b1;  // stray ack while nothing is in flight
    end
    mem_req_rdy = ($urandom_range(0, 9) < 7);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_cycle();
  endtask

  function automatic bit any_val();
    bit v = 1'b0;
    for (int t = 0; t < N; t++) v |= read_req_addr_val[t] | write_req_val[t];
    return v;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while (n < 2000 && (respq.size() != 0 || memq.size() != 0 || any_val() || outstanding)) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 2000), 64'd1);
    step();
    step();
    check({tag, "_idle"}, 64'(arb_busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [2*N-1:0]  rdy;
    logic [2*N-1:0]  rv;
    logic [N*DW-1:0] rd;
    for (int t = 0; t < N; t++) begin
      rdy[t]           = read_req_rdy[t];
      rdy[N+t]         = write_req_rdy[t];
      rv[t]            = read_resp_data_val[t];
      rv[N+t]          = write_resp_val[t];
      rd[t*DW +: DW]   = read_resp_data[t];
    end
    check({tag, "_req_rdy"}, 64'(rdy), 64'd0);
    check({tag, "_resp_val"}, 64'(rv), 64'd0);
    check({tag, "_resp_data"}, 64'(rd), 64'd0);
    check({tag, "_mem_req_val"}, 64'(mem_req_val), 64'd0);
    check({tag, "_mem_req_addr"}, 64'(mem_req_addr), 64'd0);
    check({tag, "_mem_req_data"}, 64'(mem_req_data), 64'd0);
    check({tag, "_arb_busy"}, 64'(arb_busy), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] v;
    int           n;
    for (int a = 0; a < 256; a++) begin
      phys_mem[a] = DW'($urandom);
      ref_mem[a]  = phys_mem[a];
    end
    for (int t = 0; t < N; t++) begin
      read_req_addr_val[t] = 1'b0; read_req_addr[t] = '0; read_resp_rdy[t] = 1'b0;
      write_req_val[t] = 1'b0; write_req_addr[t] = '0; write_req_data[t] = '0;
    end
    mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0;
    outstanding = 1'b0; mem_hold = 1'b0; random_en = 1'b0; lat = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1 reset = 1'b0;

    random_en = 1'b1;
    repeat (3000) step();
    random_en = 1'b0;
    drain("drain1");

    // Thread 2 load held in WAIT, then reset mid-transaction.
    mem_hold = 1'b1;
    read_req_addr_val[2] = 1'b1;
    read_req_addr[2]     = 8'h10;
    n = 0;
    while (!outstanding && n < 200) begin
      step();
      n++;
    end
    check("reach_wait", 64'(outstanding), 64'd1);
    reset = 1'b1;
    for (int t = 0; t < N; t++) begin
      read_req_addr_val[t] = 1'b0;
      write_req_val[t]     = 1'b0;
    end
    @(posedge clk);
    #1;
    reset         = 1'b0;
    outstanding   = 1'b0;
    mem_resp_val  = 1'b1;
    mem_resp_data = 16'hBEEF;
    @(negedge clk);
    check_reset_outputs("rst_wait");
    repeat (5) begin
      step();
      @(negedge clk);
      for (int t = 0; t < N; t++) v[t] = read_resp_data_val[t] | write_resp_val[t];
      check("no_late_resp", 64'(v), 64'd0);
      check("idle_after_rst", 64'(arb_busy), 64'd0);
    end

    // All threads load at once: the grant must start from thread 0.
    mem_hold = 1'b0;
    step();
    for (int t = 0; t < N; t++) begin
      read_req_addr_val[t] = 1'b1;
      read_req_addr[t]     = AW'(8'h20 + t);
    end
    @(negedge clk);
    for (int t = 0; t < N; t++) v[t] = read_req_rdy[t];
    check("first_grant_after_rst", 64'(v), 64'd1);
    drain("drain2");

    check("queues_empty", 64'(memq.size() + respq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
